// File: rtl/p_mem_loader.sv
// rtl/p_mem_loader.sv - boot loader framing a byte stream into program memory words
// Holds the core in reset until a complete, in-range image has been written.
module p_mem_loader #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       word_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] word_count_q, word_count_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] wdata_q, wdata_d;
    logic        xfer;
    logic [15:0] len_full;
    logic [15:0] count_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            len_q        <= '0;
            word_count_q <= '0;
            byte_idx_q   <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_count_q <= word_count_d;
            byte_idx_q   <= byte_idx_d;
            wdata_q      <= wdata_d;
        end
    end

    // Outputs depend on registered state only; no input reaches an output combinationally.
    assign rx_ready   = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
    assign mem_we     = (state_q == WRITE);
    assign mem_waddr  = word_count_q[ADDR_W-1:0];
    assign mem_wdata  = wdata_q;
    assign cpu_hold   = (state_q != DONE);
    assign busy       = rx_ready || (state_q == WRITE);
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERROR);
    assign word_count = word_count_q;

    assign xfer      = rx_valid && rx_ready;
    assign len_full  = {rx_data, len_q[7:0]};
    assign count_inc = word_count_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_count_d = word_count_q;
        byte_idx_d   = byte_idx_q;
        wdata_d      = wdata_q;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d      = LEN_LO;
                    len_d        = '0;
                    word_count_d = '0;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = rx_data;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_d = len_full;
                    if (len_full == 16'd0) begin
                        state_d = DONE;
                    end else if ({1'b0, len_full} > DEPTH_L) begin
                        state_d = ERROR;
                    end else begin
                        state_d    = DATA;
                        byte_idx_d = '0;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    wdata_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                word_count_d = count_inc;
                state_d      = (count_inc == len_q) ? DONE : DATA;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_p_mem_loader.sv
// tb/tb_p_mem_loader.sv - randomized self-checking bench for p_mem_loader
// Expected writes come from the image table: word k of the image lands at address k.
module tb_p_mem_loader;

    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [15:0]       word_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t_start = 0;
    int last_lat = 0;

    logic [31:0] img[DEPTH];
    int          obs_addr[$];
    logic [31:0] obs_data[$];

    p_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && mem_we) begin
            obs_addr.push_back(int'(mem_waddr));
            obs_data.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        t_start = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit sent = 0;
        int g = (gap > 0) ? $urandom_range(gap, 0) : 0;
        repeat (g) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int t = 0; t < 40 && !sent; t++) begin
            if (rx_ready) sent = 1;
            @(negedge clk);
        end
        if (!sent) check("rx_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gap);
    endtask

    task automatic fill_img(input int len);
        for (int k = 0; k < len; k++) img[k] = $urandom;
    endtask

    task automatic run_load(input int len, input int gap, input bit exp_err);
        int  k;
        bit  fin = 0;
        int  exp_words = exp_err ? 0 : len;
        obs_addr.delete();
        obs_data.delete();
        do_start();
        send_byte(len[7:0], gap);
        send_byte(len[15:8], gap);
        if (!exp_err) begin
            for (k = 0; k < len; k++) send_word(img[k], gap);
        end
        // a stray byte after the image must not be consumed
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        for (int t = 0; t < 20 && !fin; t++) begin
            if (done || error) fin = 1;
            else @(negedge clk);
        end
        last_lat = cyc - t_start;
        check("load_finished", 32'(fin), 32'd1);
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        check("done", 32'(done), 32'(!exp_err));
        check("error", 32'(error), 32'(exp_err));
        check("cpu_hold", 32'(cpu_hold), 32'(exp_err));
        check("rx_ready_end", 32'(rx_ready), 32'd0);
        check("word_count", 32'(word_count), 32'(exp_words));
        check("n_writes", 32'(obs_addr.size()), 32'(exp_words));
        for (k = 0; k < exp_words && k < obs_addr.size(); k++) begin
            check("wr_addr", 32'(obs_addr[k]), 32'(k));
            check("wr_data", obs_data[k], img[k]);
        end
    endtask

    task automatic start_pulser();
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(8, 3)) @(negedge clk);
            if (busy) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        img[0] = 32'h12345678;
        img[1] = 32'hDEADBEEF;
        run_load(2, 0, 0);
        check("lat_2words", 32'(last_lat), 32'd13);

        run_load(0, 0, 0);
        check("lat_empty", 32'(last_lat), 32'd3);
        run_load(513, 0, 1);

        fill_img(3);
        run_load(3, 0, 0);
        check("lat_3words", 32'(last_lat), 32'(3 + 5 * 3));
        run_load(3, 3, 0);
        run_load(3, 3, 0);

        for (int r = 0; r < 4; r++) begin
            int len = $urandom_range(6, 1);
            fill_img(len);
            run_load(len, $urandom_range(3, 0), 0);
        end

        fill_img(DEPTH);
        run_load(DEPTH, 0, 0);
        check("lat_depth", 32'(last_lat), 32'(3 + 5 * DEPTH));

        // reset after the 2nd byte of word 1
        fill_img(3);
        obs_addr.delete();
        obs_data.delete();
        do_start();
        send_byte(8'd3, 0);
        send_byte(8'd0, 0);
        send_word(img[0], 0);
        send_byte(img[1][7:0], 0);
        send_byte(img[1][15:8], 0);
        rx_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_mem_we", 32'(mem_we), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("mid_rst_word_count", 32'(word_count), 32'd0);
        check("mid_rst_writes", 32'(obs_addr.size()), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_done", 32'(done), 32'd0);
        fill_img(3);
        run_load(3, 2, 0);

        fill_img(6);
        fork
            run_load(6, 0, 0);
            start_pulser();
        join
        check("lat_start_ignored", 32'(last_lat), 32'(3 + 5 * 6));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/p_mem_loader.md
# p_mem_loader

Boot-time program loader for the instruction memory `p_memory`. It accepts a byte stream over a valid/ready interface (UART receiver or debug link), frames it into a length header plus little-endian 32-bit words, and drives the program memory write port. It holds the processor core in reset until a complete, in-range image has been written.

## Interface
- `DEPTH`, default 512: program memory depth in words.
- `ADDR_W`, default 9: word address width; ceil(log2(DEPTH)).

- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle pulse; begins a new load.
- `rx_data` in 8: stream byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: loader accepts a byte this cycle.
- `mem_we` out 1: program memory write strobe.
- `mem_waddr` out ADDR_W: word address of the write.
- `mem_wdata` out 32: write data.
- `cpu_hold` out 1: holds the core in reset; high unless an image is loaded.
- `busy` out 1: load in progress (states LEN_LO through WRITE).
- `done` out 1: a valid image has been loaded.
- `error` out 1: header length out of range.
- `word_count` out 16: number of words written in the current load.

## Operation
- Stream format: LEN[7:0], LEN[15:8], then LEN words, 4 bytes each, LSB first. Word k is written to address k.
- Handshake: a byte transfers on a rising edge where `rx_valid && rx_ready`. `rx_data` is sampled only on that edge.
- States:
  - IDLE: `rx_ready`=0, `cpu_hold`=1. `start` goes to LEN_LO.
  - LEN_LO: `rx_ready`=1. Transfer latches len[7:0] and goes to LEN_HI.
  - LEN_HI: `rx_ready`=1. Transfer latches len[15:8]. Using the full 16-bit length:
    - len==0 goes to DONE.
    - len>DEPTH goes to ERROR.
    - otherwise goes to DATA with byte_idx=0.
  - DATA: `rx_ready`=1. Transfer stores the byte in wdata[8*byte_idx+:8] and increments byte_idx (2 bits). On the transfer with byte_idx==3, go to WRITE.
  - WRITE: `rx_ready`=0. `mem_we`=1 for exactly one cycle, with `mem_waddr`=word_count[ADDR_W-1:0] and `mem_wdata`=assembled word. word_count increments. If the new count equals len, go to DONE; else go to DATA.
  - DONE: `done`=1, `cpu_hold`=0. `start` goes to LEN_LO.
  - ERROR: `error`=1, `cpu_hold`=1, `rx_ready`=0. `start` goes to LEN_LO.
- `start` in IDLE, DONE or ERROR clears word_count, len, `done` and `error`, and raises `cpu_hold` on the next edge. `start` in any other state is ignored.
- Bytes offered while `rx_ready`=0 are not consumed. The upstream source must hold them.
- Extra bytes after DONE are not consumed.
- Width rules:
  - len is 16 bits.
  - The len>DEPTH check uses the full 16 bits, so LEN=DEPTH is accepted.
  - word_count is 16 bits and never exceeds len.

## Timing
- Reset values:
  - State IDLE, len=0, word_count=0, byte_idx=0, wdata=0.
  - `rx_ready`=0, `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0, `cpu_hold`=1, `busy`=0, `done`=0, `error`=0.
- All outputs are decoded from registered state only. There are no combinational paths from inputs to outputs.
- `mem_we` is high in the cycle immediately after the 4th byte transfer of a word.
- With `rx_valid` held high, the minimum load time is 1 cycle (start) + 2 (header) + 5·LEN cycles. DONE is entered on the edge that ends the last WRITE cycle.
- Reset asserted mid-load:
  - Returns immediately (asynchronously) to IDLE with reset values.
  - Any partial word is discarded, and `mem_we` drops at once.
  - Words already written remain in memory, but `done` stays 0.
- `start` coincident with a byte in DONE or ERROR: `rx_ready` is 0 in those states, so no byte is consumed. The header is taken from the following cycle.

## Test plan
- Reset: after `reset` deasserts, check `cpu_hold`=1, `rx_ready`=0, `mem_we`=0, `done`=0, `error`=0, `word_count`=0.
- Load 2 words with `rx_valid` always high. Bytes: 02 00 78 56 34 12 EF BE AD DE.
  - Expect writes [0]=0x12345678 and [1]=0xDEADBEEF, each with a one-cycle `mem_we`.
  - `done`=1 and `cpu_hold`=0 exactly 13 cycles after `start`; `word_count`=2.
- Bounds:
  - Header 00 00: DONE with no `mem_we`.
  - Header 01 02 (513): ERROR, `error`=1, `cpu_hold`=1, no writes.
  - Header 00 02 (512): accepted, goes to DATA.
- Backpressure: random 0–3 idle cycles on `rx_valid` between bytes of a 3-word image. Writes must be identical to the no-gap run, and no byte may be dropped or duplicated.
- Reset mid-load: assert `reset` after the 2nd byte of word 1. Expect immediate IDLE with `mem_we`=0 and `done`=0. A following `start` plus a full image must load cleanly.
- `start` pulses during DATA are ignored: `word_count` continues, and the final image and `done` timing are unchanged.
